// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard transmitter: scan codes, one-hot
// state encoding and the frame-bit selector.
package ps2_kbd_pkg;

    localparam logic [7:0]  SC_BREAK  = 8'hF0;
    localparam logic [7:0]  SC_LSHIFT = 8'h12;
    localparam int unsigned FRAME_LEN = 11;
    localparam logic [3:0]  LAST_BIT  = 4'(FRAME_LEN - 1);

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'b0001;
    localparam state_t ST_BIT_HI = 4'b0010;
    localparam state_t ST_BIT_LO = 4'b0100;
    localparam state_t ST_GAP    = 4'b1000;

    // Line value for position idx of an 11-bit frame: start, 8 data LSB first, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
        logic bit_v;
        case (idx)
            4'd0:    bit_v = 1'b0;
            4'd1:    bit_v = data[0];
            4'd2:    bit_v = data[1];
            4'd3:    bit_v = data[2];
            4'd4:    bit_v = data[3];
            4'd5:    bit_v = data[4];
            4'd6:    bit_v = data[5];
            4'd7:    bit_v = data[6];
            4'd8:    bit_v = data[7];
            4'd9:    bit_v = ~^data;
            default: bit_v = 1'b1;
        endcase
        return bit_v;
    endfunction

endpackage

// File: rtl/ps2_kbd_tx_ascii_to_scancode.sv
// Combinational ASCII to Set-2 make-code lookup for digits and letters;
// uppercase letters reuse the lowercase code and flag the need for shift.
module ascii_to_scancode
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] ascii,
    output logic [7:0] code,
    output logic       shifted,
    output logic       valid
);

    logic       w_is_upper;
    logic [7:0] w_lower;

    assign w_is_upper = (ascii >= 8'h41) && (ascii <= 8'h5A);
    assign w_lower    = w_is_upper ? (ascii | 8'h20) : ascii;
    assign shifted    = w_is_upper;

    // Lookup on the case-folded character.
    always_comb begin
        code  = 8'h00;
        valid = 1'b1;
        case (w_lower)
            8'h31: code = 8'h16;
            8'h32: code = 8'h1E;
            8'h33: code = 8'h26;
            8'h34: code = 8'h25;
            8'h35: code = 8'h2E;
            8'h36: code = 8'h36;
            8'h37: code = 8'h3D;
            8'h38: code = 8'h3E;
            8'h39: code = 8'h46;
            8'h30: code = 8'h45;
            8'h61: code = 8'h1C;
            8'h62: code = 8'h32;
            8'h63: code = 8'h21;
            8'h64: code = 8'h23;
            8'h65: code = 8'h24;
            8'h66: code = 8'h2B;
            8'h67: code = 8'h34;
            8'h68: code = 8'h33;
            8'h69: code = 8'h43;
            8'h6A: code = 8'h3B;
            8'h6B: code = 8'h42;
            8'h6C: code = 8'h4B;
            8'h6D: code = 8'h3A;
            8'h6E: code = 8'h31;
            8'h6F: code = 8'h44;
            8'h70: code = 8'h4D;
            8'h71: code = 8'h15;
            8'h72: code = 8'h2D;
            8'h73: code = 8'h1B;
            8'h74: code = 8'h2C;
            8'h75: code = 8'h3C;
            8'h76: code = 8'h2A;
            8'h77: code = 8'h1D;
            8'h78: code = 8'h22;
            8'h79: code = 8'h35;
            8'h7A: code = 8'h1A;
            default: begin
                code  = 8'h00;
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard: turns key events into Set-2 byte sequences and
// shifts them out as 11-bit frames with the device generating ps2_clk.
module ps2_kbd_tx
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ev_valid,
    input  logic [7:0] ev_ascii,
    input  logic       ev_release,
    output logic       ev_ready,
    output logic       ps2_clk,
    output logic       ps2_dat,
    output logic       busy,
    output logic       err_unmapped
);

    localparam int unsigned      CNT_W     = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(2 * CLK_DIV - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bit_idx;
    logic [3:0]       w_bit_idx_nxt;
    logic [1:0]       r_byte_idx;
    logic [1:0]       w_byte_idx_nxt;
    logic [2:0]       r_nbytes;
    logic [2:0]       w_nbytes;
    logic [3:0][7:0]  r_seq;
    logic [3:0][7:0]  w_seq;
    logic             r_ev_ready;
    logic             r_ps2_clk;
    logic             r_ps2_dat;
    logic             r_busy;
    logic             r_err;
    logic             w_ps2_clk_nxt;
    logic             w_ps2_dat_nxt;
    logic [7:0]       w_code;
    logic             w_shifted;
    logic             w_map_valid;
    logic             w_accept;
    logic             w_start;
    logic             w_half_done;
    logic             w_gap_done;
    logic             w_last_bit;
    logic             w_more_bytes;
    logic [2:0]       w_byte_cnt_nxt;
    logic [3:0]       w_bit_idx_inc;

    ascii_to_scancode u_map (
        .ascii   (ev_ascii),
        .code    (w_code),
        .shifted (w_shifted),
        .valid   (w_map_valid)
    );

    assign w_accept       = ev_valid && r_ev_ready && (r_state == ST_IDLE);
    assign w_start        = w_accept && w_map_valid;
    assign w_half_done    = (r_cnt == HALF_LAST);
    assign w_gap_done     = (r_cnt == GAP_LAST);
    assign w_last_bit     = (r_bit_idx == LAST_BIT);
    assign w_byte_cnt_nxt = {1'b0, r_byte_idx} + 3'd1;
    assign w_more_bytes   = (w_byte_cnt_nxt < r_nbytes);
    assign w_bit_idx_inc  = r_bit_idx + 4'd1;

    // Byte sequence for the offered event: optional break/shift prefix and shift-release suffix.
    always_comb begin
        w_seq    = '0;
        w_nbytes = 3'd0;
        case ({w_shifted, ev_release})
            2'b00: begin
                w_seq[0] = w_code;
                w_nbytes = 3'd1;
            end
            2'b01: begin
                w_seq[0] = SC_BREAK;
                w_seq[1] = w_code;
                w_nbytes = 3'd2;
            end
            2'b10: begin
                w_seq[0] = SC_LSHIFT;
                w_seq[1] = w_code;
                w_nbytes = 3'd2;
            end
            2'b11: begin
                w_seq[0] = SC_BREAK;
                w_seq[1] = w_code;
                w_seq[2] = SC_BREAK;
                w_seq[3] = SC_LSHIFT;
                w_nbytes = 3'd4;
            end
            default: begin
                w_seq    = '0;
                w_nbytes = 3'd0;
            end
        endcase
    end

    // State, counters, sequence buffer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 4'd0;
            r_byte_idx <= 2'd0;
            r_nbytes   <= 3'd0;
            r_seq      <= '0;
            r_ev_ready <= 1'b0;
            r_ps2_clk  <= 1'b1;
            r_ps2_dat  <= 1'b1;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= ((w_state_nxt != r_state) || (r_state == ST_IDLE)) ? '0 : r_cnt + CNT_W'(1);
            r_bit_idx  <= w_bit_idx_nxt;
            r_byte_idx <= w_byte_idx_nxt;
            if (w_start) begin
                r_seq    <= w_seq;
                r_nbytes <= w_nbytes;
            end else begin
                r_seq    <= r_seq;
                r_nbytes <= r_nbytes;
            end
            r_ev_ready <= (w_state_nxt == ST_IDLE);
            r_ps2_clk  <= w_ps2_clk_nxt;
            r_ps2_dat  <= w_ps2_dat_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_err      <= w_accept && !w_map_valid;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) w_state_nxt = ST_BIT_HI;
                else         w_state_nxt = ST_IDLE;
            end
            ST_BIT_HI: begin
                if (w_half_done) w_state_nxt = ST_BIT_LO;
                else             w_state_nxt = ST_BIT_HI;
            end
            ST_BIT_LO: begin
                if (w_half_done) w_state_nxt = w_last_bit ? ST_GAP : ST_BIT_HI;
                else             w_state_nxt = ST_BIT_LO;
            end
            ST_GAP: begin
                if (w_gap_done) w_state_nxt = w_more_bytes ? ST_BIT_HI : ST_IDLE;
                else            w_state_nxt = ST_GAP;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Line and index updates; data only moves on BIT_HI entry so it is stable across the falling edge.
    always_comb begin
        w_ps2_clk_nxt  = (w_state_nxt != ST_BIT_LO);
        w_ps2_dat_nxt  = r_ps2_dat;
        w_bit_idx_nxt  = r_bit_idx;
        w_byte_idx_nxt = r_byte_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_bit_idx_nxt  = 4'd0;
                    w_byte_idx_nxt = 2'd0;
                    w_ps2_dat_nxt  = frame_bit(w_seq[0], 4'd0);
                end else begin
                    w_ps2_dat_nxt  = 1'b1;
                end
            end
            ST_BIT_HI: begin
                w_ps2_dat_nxt = r_ps2_dat;
            end
            ST_BIT_LO: begin
                if (w_half_done && !w_last_bit) begin
                    w_bit_idx_nxt = w_bit_idx_inc;
                    w_ps2_dat_nxt = frame_bit(r_seq[r_byte_idx], w_bit_idx_inc);
                end else begin
                    w_ps2_dat_nxt = r_ps2_dat;
                end
            end
            ST_GAP: begin
                if (w_gap_done && w_more_bytes) begin
                    w_bit_idx_nxt  = 4'd0;
                    w_byte_idx_nxt = w_byte_cnt_nxt[1:0];
                    w_ps2_dat_nxt  = frame_bit(r_seq[w_byte_cnt_nxt[1:0]], 4'd0);
                end else begin
                    w_ps2_dat_nxt  = 1'b1;
                end
            end
            default: begin
                w_ps2_dat_nxt  = 1'b1;
                w_bit_idx_nxt  = 4'd0;
                w_byte_idx_nxt = 2'd0;
            end
        endcase
    end

    assign ev_ready     = r_ev_ready;
    assign ps2_clk      = r_ps2_clk;
    assign ps2_dat      = r_ps2_dat;
    assign busy         = r_busy;
    assign err_unmapped = r_err;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line-level frame decoder and
// protocol monitor compared against a table-driven key-event model.
module tb_ps2_kbd_tx;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned BYTE_CYC = 24 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ev_valid = 1'b0;
    logic [7:0] ev_ascii = 8'h00;
    logic       ev_release = 1'b0;
    logic       ev_ready;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       busy;
    logic       err_unmapped;

    always #5 clk = ~clk;

    ps2_kbd_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .ev_valid     (ev_valid),
        .ev_ascii     (ev_ascii),
        .ev_release   (ev_release),
        .ev_ready     (ev_ready),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .busy         (busy),
        .err_unmapped (err_unmapped)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: key tables and byte-sequence rules.
    byte unsigned letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                     8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                     8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digit_sc [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    byte unsigned exp_q [$];
    byte unsigned rx_q  [$];

    function automatic bit model_push(input byte unsigned a, input bit rel);
        byte unsigned code;
        bit shift;
        int ai = int'(a);
        if (ai >= 97 && ai <= 122) begin
            code = letter_sc[ai - 97]; shift = 1'b0;
        end else if (ai >= 65 && ai <= 90) begin
            code = letter_sc[ai - 65]; shift = 1'b1;
        end else if (ai >= 48 && ai <= 57) begin
            code = digit_sc[ai - 48];  shift = 1'b0;
        end else begin
            return 1'b0;
        end
        if (rel)        exp_q.push_back(8'hF0);
        else if (shift) exp_q.push_back(8'h12);
        exp_q.push_back(code);
        if (rel && shift) begin
            exp_q.push_back(8'hF0);
            exp_q.push_back(8'h12);
        end
        return 1'b1;
    endfunction

    // Line monitor: decodes frames at ps2_clk falling edges and tracks protocol violations.
    logic        prev_clk = 1'b1;
    logic        prev_dat = 1'b1;
    int          nbits = 0;
    int          hi_len = 0;
    int          lo_len = 0;
    logic [10:0] frm = '0;
    logic [10:0] last_frame = '0;
    int          viol_dat = 0;
    int          viol_phase = 0;
    int          frame_bad = 0;
    int          fall_cnt = 0;
    int          err_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_clk = 1'b1; prev_dat = 1'b1; nbits = 0; hi_len = 0; lo_len = 0;
        end else begin
            if (err_unmapped) err_cnt++;
            if (!ps2_clk && (ps2_dat !== prev_dat)) viol_dat++;
            if (prev_clk && !ps2_clk) begin
                fall_cnt++;
                if (nbits >= 1 && nbits <= 10 && hi_len != CLK_DIV) viol_phase++;
                frm[nbits] = ps2_dat;
                nbits++;
                lo_len = 1;
                if (nbits == 11) begin
                    if (frm[0] !== 1'b0 || frm[10] !== 1'b1 || (^frm[9:1]) !== 1'b1) frame_bad++;
                    rx_q.push_back(frm[8:1]);
                    last_frame = frm;
                    nbits = 0;
                end
            end else if (!prev_clk && ps2_clk) begin
                if (lo_len != CLK_DIV) viol_phase++;
                hi_len = 1;
            end else if (ps2_clk) begin
                hi_len++;
            end else begin
                lo_len++;
            end
            prev_clk = ps2_clk;
            prev_dat = ps2_dat;
        end
    end

    task automatic start_event(input byte unsigned a, input bit rel);
        int guard = 0;
        @(negedge clk);
        while (!ev_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check_eq("start_wait_ready", ev_ready, 1);
        ev_ascii = a; ev_release = rel; ev_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int exp_cyc);
        int cyc = 0;
        int busy_low = 0;
        while (!ev_ready && cyc < exp_cyc + 50) begin
            if (!busy) busy_low++;
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_ready_lat"}, cyc, exp_cyc);
        check_eq({tag, "_busy_hold"}, busy_low, 0);
        check_eq({tag, "_busy_end"}, busy, 0);
    endtask

    task automatic compare_rx(input string tag);
        logic [31:0] got;
        check_eq({tag, "_nbytes"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hDEAD;
            check_eq($sformatf("%s_byte%0d", tag, i), got, 32'(exp_q[i]));
        end
        check_eq({tag, "_dat_stable"}, viol_dat, 0);
        check_eq({tag, "_phase_len"}, viol_phase, 0);
        check_eq({tag, "_frame_fmt"}, frame_bad, 0);
    endtask

    task automatic run_event(input string tag, input byte unsigned a, input bit rel);
        bit mapped;
        int e0;
        int f0;
        exp_q.delete();
        rx_q.delete();
        e0 = err_cnt;
        f0 = fall_cnt;
        mapped = model_push(a, rel);
        start_event(a, rel);
        if (mapped) begin
            wait_ready(tag, exp_q.size() * BYTE_CYC);
        end else begin
            check_eq({tag, "_ready_stay"}, ev_ready, 1);
            check_eq({tag, "_err_pulse"}, err_unmapped, 1);
            repeat (2 * BYTE_CYC) @(negedge clk);
            check_eq({tag, "_no_clk"}, fall_cnt - f0, 0);
        end
        compare_rx(tag);
        check_eq({tag, "_err_cnt"}, err_cnt - e0, mapped ? 0 : 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte unsigned a;
        bit rel;
        int sel;

        repeat (3) @(negedge clk);
        check_eq("rst_ps2_clk", ps2_clk, 1);
        check_eq("rst_ps2_dat", ps2_dat, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_err", err_unmapped, 0);
        check_eq("rst_ready", ev_ready, 0);
        rst_n = 1'b1;
        #1 check_eq("ready_low_before_edge", ev_ready, 0);
        @(negedge clk);
        check_eq("ready_after_first_edge", ev_ready, 1);

        run_event("a_press", 8'h61, 1'b0);
        check_eq("a_frame_bits", last_frame, 11'h438);

        run_event("one_rel", 8'h31, 1'b1);

        // Shifted release with a back-to-back press held on ev_valid throughout.
        exp_q.delete();
        rx_q.delete();
        void'(model_push(8'h41, 1'b1));
        void'(model_push(8'h7A, 1'b0));
        start_event(8'h41, 1'b1);
        ev_ascii = 8'h7A; ev_release = 1'b0; ev_valid = 1'b1;
        wait_ready("shift_rel", 4 * BYTE_CYC);
        @(posedge clk);
        @(negedge clk);
        ev_valid = 1'b0;
        check_eq("b2b_accept", ev_ready, 0);
        wait_ready("b2b_z", BYTE_CYC);
        compare_rx("b2b");

        run_event("hash", 8'h23, 1'b0);

        // Reset in the middle of a frame.
        exp_q.delete();
        rx_q.delete();
        start_event(8'h71, 1'b0);
        repeat (30) @(posedge clk);
        #1 check_eq("midframe_clk_low", ps2_clk, 0);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_clk", ps2_clk, 1);
        check_eq("rst_mid_dat", ps2_dat, 1);
        check_eq("rst_mid_busy", busy, 0);
        check_eq("rst_mid_ready", ev_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
        @(negedge clk);
        check_eq("rst_mid_ready_rise", ev_ready, 1);
        run_event("b_after_rst", 8'h62, 1'b0);

        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       a = 8'($urandom_range(32, 126));
                1:       a = 8'($urandom_range(97, 122));
                2:       a = 8'($urandom_range(65, 90));
                default: a = 8'($urandom_range(48, 57));
            endcase
            rel = 1'($urandom_range(0, 1));
            run_event($sformatf("rnd%0d_%0h_%0d", i, a, rel), a, rel);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
